// File: rtl/nor_mult_pkg.sv
// Shared types and elaboration helpers for the NOR-form sequential multiplier.
package nor_mult_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold values 0 .. steps-1 (never below 1 bit)
    function automatic int unsigned cnt_width(input int unsigned steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

    // Legal configuration: a whole number of coefficient bits per RUN cycle
    function automatic bit bpc_divides(input int unsigned coef_w, input int unsigned bpc);
        return (bpc != 0) && ((coef_w % bpc) == 0);
    endfunction

endpackage

// File: rtl/nor_pp_row.sv
// One gated partial-product row in NOR form.
//   a    : multiplicand row (W bits)
//   b    : multiplier bit gating the row
//   zero : force-to-zero clear term
//   pp_c : a & {W{b}} unless zero is set (combinational)
module nor_pp_row #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic         b,
    input  logic         zero,
    output logic [W-1:0] pp_c
);

    // De Morgan: ~(~a | ~b | z) == a & b & ~z, kept in NOR form for the library mapping
    assign pp_c = ~(~a | ~{W{b}} | {W{zero}});

endmodule

// File: rtl/nor_pp_seq_mult.sv
// Multi-cycle unsigned shift-and-add multiplier with zero-skip early termination.
// Consumes BITS_PER_CYC multiplier bits per RUN cycle; latency follows the
// highest set coefficient bit.
//   clk, rst            : clock, asynchronous active-high reset
//   clr                 : synchronous abort, discards any pending product
//   in_valid/in_ready   : operand handshake (in_data x in_coef)
//   out_valid/out_ready : product handshake, out_prod masked to 0 when not valid
module nor_pp_seq_mult
    import nor_mult_pkg::*;
#(
    parameter  int unsigned DATA_W       = 12,
    parameter  int unsigned COEF_W       = 12,
    parameter  int unsigned BITS_PER_CYC = 1,
    localparam int unsigned PROD_W       = DATA_W + COEF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod
);

    localparam int unsigned NSTEP = (BITS_PER_CYC == 0) ? 1 : COEF_W / BITS_PER_CYC;
    localparam int unsigned CNT_W = cnt_width(NSTEP);

    if (!bpc_divides(COEF_W, BITS_PER_CYC)) begin : g_bad_bpc
        $error("nor_pp_seq_mult: BITS_PER_CYC must divide COEF_W");
    end

    state_t              state_q, state_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   a_q, a_d;
    logic [COEF_W-1:0]   b_q, b_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_d;
    logic                out_valid_d;
    logic [PROD_W-1:0]   out_prod_d;

    logic [COEF_W-1:0]   b_shift;
    logic [PROD_W-1:0]   pp;
    logic                pp_zero;
    logic [PROD_W-1:0]   rows [BITS_PER_CYC];

    // Rows only contribute while actually running and not being aborted
    assign pp_zero = (state_q != RUN) || clr;

    // One gated row per multiplier bit consumed this cycle
    for (genvar k = 0; k < BITS_PER_CYC; k++) begin : g_row
        nor_pp_row #(
            .W(PROD_W)
        ) u_row (
            .a    (a_q),
            .b    (b_q[k]),
            .zero (pp_zero),
            .pp_c (rows[k])
        );
    end

    // Weighted sum of this cycle's rows
    always_comb begin
        pp = '0;
        for (int k = 0; k < BITS_PER_CYC; k++) begin
            pp = pp + (rows[k] << k);
        end
    end

    assign b_shift = b_q >> BITS_PER_CYC;

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_prod  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_prod  <= out_prod_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_prod_d  = '0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d   = PROD_W'(in_data);
                    b_d   = in_coef;
                    acc_d = '0;
                    cnt_d = '0;
                    // A zero operand means the product is already known
                    if ((in_data == '0) || (in_coef == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = acc_q + pp;
                a_d   = a_q << BITS_PER_CYC;
                b_d   = b_shift;
                cnt_d = cnt_q + CNT_W'(1);
                // Stop once no set multiplier bits remain above this slice
                if ((b_shift == '0) || (cnt_q == CNT_W'(NSTEP - 1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over every transition
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            a_d     = '0;
            b_d     = '0;
            cnt_d   = '0;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        out_prod_d  = out_valid_d ? acc_d : '0;
    end

endmodule

// File: tb/tb_nor_pp_seq_mult.sv
// Self-checking bench for nor_pp_seq_mult: directed scenarios on a default
// instance plus a randomised sweep per BITS_PER_CYC in {1,2,3,4}.
module tb_nor_pp_seq_mult;

    localparam int unsigned DW    = 12;
    localparam int unsigned CW    = 12;
    localparam int unsigned PW    = DW + CW;
    localparam int          SWEEP = 1000;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_coef;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_prod;

    int n_total;
    int n_pass;

    logic [PW-1:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nor_pp_seq_mult #(
        .DATA_W       (DW),
        .COEF_W       (CW),
        .BITS_PER_CYC (1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Edges from accept (inclusive) until out_valid is seen
    function automatic int lat_model(input logic [DW-1:0] d, input logic [CW-1:0] c, input int bpc);
        int msb;
        if (d == '0 || c == '0) return 1;
        msb = 0;
        for (int i = 0; i < int'(CW); i++) begin
            if (c[i]) msb = i;
        end
        return (msb + bpc) / bpc + 1;
    endfunction

    task automatic wait_ready();
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) chk("rdy_timeout", 0, 1);
    endtask

    // Present operands and return after the accept edge
    task automatic accept(input logic [DW-1:0] d, input logic [CW-1:0] c);
        wait_ready();
        in_data  = d;
        in_coef  = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Full operation: latency, busy in_ready, optional backpressure, product
    task automatic issue_op(input logic [DW-1:0] d, input logic [CW-1:0] c,
                            input int lat_exp, input int hold);
        int            edges;
        bit            busy_rdy;
        bit            stable;
        logic [PW-1:0] held;
        logic [PW-1:0] expv;
        exp_q.push_back(PW'(d) * PW'(c));
        out_ready = 1'b0;
        accept(d, c);
        edges    = 1;
        busy_rdy = 1'b0;
        while (!out_valid && edges < 64) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", edges, lat_exp);
        chk("busy_in_ready", busy_rdy, 0);
        stable = 1'b1;
        held   = out_prod;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (out_prod !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk("hold_stable", stable, 1);
        expv = exp_q.pop_front();
        chk("prod", out_prod, expv);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
        chk("post_prod_mask", out_prod, 0);
    endtask

    // Randomised sweep per multiplier width-per-cycle
    for (genvar g = 1; g <= 4; g++) begin : g_sweep
        logic          rst_s;
        logic          clr_s;
        logic          iv;
        logic          ir;
        logic [DW-1:0] id;
        logic [CW-1:0] ic;
        logic          ov;
        logic          ordy;
        logic [PW-1:0] op;
        logic [PW-1:0] sq [$];
        bit            done;

        nor_pp_seq_mult #(
            .DATA_W       (DW),
            .COEF_W       (CW),
            .BITS_PER_CYC (g)
        ) u_sdut (
            .clk       (clk),
            .rst       (rst_s),
            .clr       (clr_s),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_data   (id),
            .in_coef   (ic),
            .out_valid (ov),
            .out_ready (ordy),
            .out_prod  (op)
        );

        initial begin
            logic [DW-1:0] d;
            logic [CW-1:0] c;
            logic [PW-1:0] held;
            logic [PW-1:0] expv;
            int            lat;
            int            edges;
            int            w;
            int            hold;
            bit            stable;
            done  = 1'b0;
            rst_s = 1'b1;
            clr_s = 1'b0;
            iv    = 1'b0;
            ordy  = 1'b0;
            id    = '0;
            ic    = '0;
            repeat (2) @(posedge clk);
            #1 rst_s = 1'b0;
            for (int i = 0; i < SWEEP; i++) begin
                case (i)
                    0:       begin d = 12'hFFF; c = 12'hFFF; end
                    1:       begin d = 12'hFFF; c = 12'h010; end
                    2:       begin d = 12'h0A5; c = 12'h000; end
                    3:       begin d = 12'h000; c = 12'h5A5; end
                    default: begin
                        d = DW'($urandom);
                        c = CW'($urandom) >> $urandom_range(0, 11);
                        if ($urandom_range(0, 15) == 0) d = '0;
                    end
                endcase
                sq.push_back(PW'(d) * PW'(c));
                lat = lat_model(d, c, g);
                w = 0;
                while (!ir && w < 50) begin
                    @(posedge clk); #1;
                    w++;
                end
                if (!ir) chk($sformatf("b%0d_rdy_timeout", g), 0, 1);
                id = d;
                ic = c;
                iv = 1'b1;
                @(posedge clk); #1;
                iv = 1'b0;
                edges = 1;
                while (!ov && edges < 40) begin
                    @(posedge clk); #1;
                    edges++;
                end
                chk($sformatf("b%0d_latency d=%0h c=%0h", g, d, c), edges, lat);
                hold   = $urandom_range(0, 2);
                held   = op;
                stable = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    if (op !== held || ov !== 1'b1) stable = 1'b0;
                end
                if (hold > 0) chk($sformatf("b%0d_hold", g), stable, 1);
                expv = sq.pop_front();
                chk($sformatf("b%0d_prod d=%0h c=%0h", g, d, c), op, expv);
                ordy = 1'b1;
                @(posedge clk); #1;
                ordy = 1'b0;
            end
            done = 1'b1;
        end
    end

    initial begin
        int  cyc;
        bit  seen_valid;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_coef   = '0;
        out_ready = 1'b0;
        n_total   = 0;
        n_pass    = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_prod", out_prod, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1);

        // Full-width operands, short coefficient, zero-skip
        issue_op(12'hFFF, 12'hFFF, 13, 0);
        issue_op(12'h123, 12'h001, 2, 0);
        issue_op(12'h0A5, 12'h000, 1, 0);

        // Backpressure in DONE
        issue_op(12'h010, 12'h010, 6, 5);

        // clr in IDLE rejects the operands
        in_data  = 12'h321;
        in_coef  = 12'h00F;
        in_valid = 1'b1;
        clr      = 1'b1;
        chk("clr_idle_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        clr      = 1'b0;
        chk("clr_idle_no_accept", in_ready, 1);
        chk("clr_idle_out_valid", out_valid, 0);

        // clr on the 4th RUN cycle discards the operation
        accept(12'hFFF, 12'hFFF);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_run_in_ready", in_ready, 1);
        seen_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("clr_run_no_valid", seen_valid, 0);
        issue_op(12'h002, 12'h003, 3, 0);

        // Async reset mid-RUN, between edges
        accept(12'hFFF, 12'hFFF);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_run_in_ready", in_ready, 0);
        chk("arst_run_out_valid", out_valid, 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_run_idle", in_ready, 1);

        // Async reset while a product waits in DONE
        accept(12'h010, 12'h001);
        @(posedge clk); #1;
        chk("arst_done_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_done_out_valid", out_valid, 0);
        chk("arst_done_out_prod", out_prod, 0);
        chk("arst_done_in_ready", in_ready, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_done_idle", in_ready, 1);
        issue_op(12'h123, 12'h001, 2, 0);

        // Wait for the width sweeps
        cyc = 0;
        while (!(g_sweep[1].done && g_sweep[2].done && g_sweep[3].done && g_sweep[4].done)
               && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(g_sweep[1].done && g_sweep[2].done && g_sweep[3].done && g_sweep[4].done)) begin
            chk("sweep_timeout", 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nor_pp_seq_mult.md
Name: nor_pp_seq_mult

Overview:
Parametrised, multi-cycle unsigned shift-and-add multiplier for the 2D FIR datapath, processing BITS_PER_CYC coefficient bits per clock. Each partial product is generated in NOR form, pp = ~(~a | ~{DATA_W{b_bit}}), and forced to zero by a clear term. Zero-skip early termination makes latency track the highest set coefficient bit. Sits between the coefficient/pixel fetch stage and the tap accumulator, with valid/ready on both sides.

Parameters:
DATA_W, 12, pixel/data operand width (unsigned)
COEF_W, 12, coefficient operand width (unsigned)
BITS_PER_CYC, 1, coefficient bits consumed per RUN cycle; must divide COEF_W (elaboration error otherwise)
PROD_W, DATA_W+COEF_W, derived product width; not to be overridden

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous abort; zeroes accumulator and returns to IDLE
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_data  input  DATA_W  multiplicand
in_coef  input  COEF_W  multiplier
out_valid  output  1  product valid
out_ready  input  1  downstream accepts product
out_prod  output  PROD_W  unsigned product

Behaviour:
- Reset: while rst=1, all outputs are low (in_ready=0, out_valid=0, out_prod=0). State is IDLE; acc, a_sh, b_sh and cnt are 0. The first cycle after release is IDLE with in_ready=1.
- States:
  - IDLE: in_ready=1. An accept is in_valid&in_ready at a clock edge.
  - RUN: in_ready=0.
  - DONE: out_valid=1.
- Accept, IDLE->RUN:
  - a_sh <= in_data, zero-extended to PROD_W.
  - b_sh <= in_coef.
  - acc <= 0, cnt <= 0.
  - If in_data==0 or in_coef==0, go directly to DONE with acc=0.
- RUN, per cycle:
  - pp = sum over k<BITS_PER_CYC of (NOR partial product of a_sh with b_sh[k]) << k.
  - acc <= acc + pp, truncated to PROD_W. The sum cannot overflow.
  - a_sh <<= BITS_PER_CYC; b_sh >>= BITS_PER_CYC; cnt++.
  - Go to DONE when the shifted b_sh becomes 0, or when cnt reaches COEF_W/BITS_PER_CYC-1.
- RUN cycle count: N = ceil((msb_index(in_coef)+1)/BITS_PER_CYC), with 1 <= N <= COEF_W/BITS_PER_CYC.
- Latency: out_valid rises N+1 edges after the accept edge (1 edge for zero operands).
- DONE: out_prod = acc, held stable with out_valid until out_valid&out_ready. That handshake moves the block to IDLE. No same-cycle re-accept: in_ready rises the cycle after the product handshake (no bypass).
- out_prod reads 0 whenever out_valid=0. Output is masked; acc itself is not cleared.
- clr: sampled every cycle and has priority over all transitions. Next state is IDLE, acc/a_sh/b_sh/cnt are zeroed, and any pending product is discarded without an out_valid handshake. clr in IDLE together with in_valid=1 rejects the operands; in_ready still reads 1 that cycle, but no accept happens.
- Async rst mid-RUN/DONE: immediate return to reset values; no partial result is emitted.
- Arithmetic: unsigned only. Exact product for all operand values, e.g. max*max = (2^DATA_W-1)(2^COEF_W-1).

Decomposition:
- Package nor_mult_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - a clog2-based width function for cnt
  - a constant checking that BITS_PER_CYC divides COEF_W
- Sub-module nor_pp_row (combinational, parametrised width): ~(~a | ~{W{bit}} | {W{zero}}), giving a gated partial product with force-to-zero. Instantiate BITS_PER_CYC copies in a generate loop.

Test Plan:
1. Defaults: in_data=12'hFFF, in_coef=12'hFFF, out_ready=1 -> out_prod=24'hFFE001; out_valid rises 13 edges after accept (N=12); in_ready=0 throughout.
2. in_data=12'h123, in_coef=12'h001 -> out_prod=24'h000123 after 2 edges. in_data=12'h0A5, in_coef=12'h000 -> out_prod=0 after 1 edge (zero-skip).
3. Backpressure: in_data=12'h010, in_coef=12'h010, out_ready=0 for 5 cycles -> out_valid=1 and out_prod=24'h000100 held stable, in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
4. clr pulse on 4th RUN cycle of a 12'hFFF x 12'hFFF op -> next cycle IDLE, out_valid never rises. A following op 12'h002 x 12'h003 gives 24'h000006 (no stale acc).
5. Async rst asserted mid-RUN, between clock edges -> in_ready/out_valid/out_prod go 0 immediately. After release: IDLE, in_ready=1.
6. BITS_PER_CYC=4: in_coef=12'hFFF, in_data=12'hFFF -> N=3, out_prod=24'hFFE001 at 4 edges. in_coef=12'h010 -> N=2. Random 1000-op sweep against a golden model for BITS_PER_CYC in {1,2,3,4}.
